blocks: RTL and testbench

Brick-field manager for Breakout; sits directly upstream of the ball stage. Holds the alive/dead state of a 10×4 brick wall and scans the wall sequentially whenever the ball centre moves. Produces the `hit_block` and side flags the ball consumes, plus the score, the remaining-brick count and a per-pixel `area` signal for the VGA mixer.

---
 rtl/blocks_pkg.sv | 40 ++++
 rtl/blocks_if.sv | 24 ++
 rtl/blocks_brick_overlap.sv | 53 +++++
 rtl/blocks.sv | 155 +++++++++++++++
 tb/tb_blocks.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/blocks_pkg.sv
// Purpose: shared geometry, FSM state and side encodings for the Breakout brick field.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
package breakout_pkg;

    // Wall geometry; BRICK_W and BRICK_H are powers of two so pixel lookup is a bit slice.
    localparam int COLS     = 10;
    localparam int ROWS     = 4;
    localparam int BRICK_W  = 64;
    localparam int BRICK_H  = 16;
    localparam int TOP      = 64;
    localparam int R_BALL   = 8;
    localparam int N_BRICKS = COLS * ROWS;

    localparam logic [5:0] LAST_IDX = 6'(N_BRICKS - 1);
    localparam logic [9:0] HOME_X   = 10'd320;
    localparam logic [9:0] HOME_Y   = 10'd240;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SCAN   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Side the ball entered the brick from, one-hot {u, d, l, r}.
    localparam logic [3:0] SIDE_U = 4'b1000;
    localparam logic [3:0] SIDE_D = 4'b0100;
    localparam logic [3:0] SIDE_L = 4'b0010;
    localparam logic [3:0] SIDE_R = 4'b0001;

    // Signed coordinate type: one extra bit so x-R near the left edge stays negative.
    typedef logic signed [10:0] sc_t;

    // Top row is worth the most points.
    function automatic logic [2:0] brick_points(input logic [5:0] idx);
        return 3'(ROWS - (int'(idx) / COLS));
    endfunction

endpackage

// File: rtl/blocks_if.sv
// Purpose: ball-stage link - ball centre into the brick field, hit flags back out.
// Latency: wires only.
// Backpressure: none; flags are level signals held until the next scan starts.
interface blocks_if;
    logic [9:0] x_ball;
    logic [9:0] y_ball;
    logic       hit_block;
    logic       hit_block_u;
    logic       hit_block_d;
    logic       hit_block_l;
    logic       hit_block_r;

    // Ball stage drives the centre and consumes the flags.
    modport master (
        output x_ball, y_ball,
        input  hit_block, hit_block_u, hit_block_d, hit_block_l, hit_block_r
    );

    // Brick field consumes the centre and drives the flags.
    modport slave (
        input  x_ball, y_ball,
        output hit_block, hit_block_u, hit_block_d, hit_block_l, hit_block_r
    );
endinterface

// File: rtl/blocks_brick_overlap.sv
// Purpose: ball-box vs brick overlap test plus entry-side classification for one brick index.
// Latency: combinational. Ports: x_i/y_i ball centre, idx_i brick, overlap_o, side_o one-hot {u,d,l,r}.
// Backpressure: none.
module brick_overlap
    import breakout_pkg::*;
(
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic [5:0] idx_i,
    output logic       overlap_o,
    output logic [3:0] side_o
);

    logic [3:0] col;
    logic [1:0] row;
    sc_t        left, right, top, bottom;
    sc_t        xs, ys;
    sc_t        du, dd, dl, dr;

    always_comb begin
        col    = 4'(int'(idx_i) % COLS);
        row    = 2'(int'(idx_i) / COLS);

        // Brick box is inset by one pixel on every side, leaving a 1-px gap line.
        left   = sc_t'(col) * sc_t'(BRICK_W) + sc_t'(1);
        right  = left + sc_t'(BRICK_W - 3);
        top    = sc_t'(TOP) + sc_t'(row) * sc_t'(BRICK_H) + sc_t'(1);
        bottom = top + sc_t'(BRICK_H - 3);

        xs     = sc_t'({1'b0, x_i});
        ys     = sc_t'({1'b0, y_i});

        // Penetration depth through each face; all non-negative means the boxes overlap.
        du     = (ys + sc_t'(R_BALL)) - top;
        dd     = bottom - (ys - sc_t'(R_BALL));
        dl     = (xs + sc_t'(R_BALL)) - left;
        dr     = right - (xs - sc_t'(R_BALL));

        overlap_o = !du[10] && !dd[10] && !dl[10] && !dr[10];

        // Shallowest penetration names the entry face; ties favour u, then d, then l.
        if ((du <= dd) && (du <= dl) && (du <= dr)) begin
            side_o = SIDE_U;
        end else if ((dd <= dl) && (dd <= dr)) begin
            side_o = SIDE_D;
        end else if (dl <= dr) begin
            side_o = SIDE_L;
        end else begin
            side_o = SIDE_R;
        end
    end

endmodule

// File: rtl/blocks.sv
// Purpose: 10x4 brick wall state, sequential hit scan on each ball move, score/count, per-pixel area.
// Latency: hit on brick k commits k+2 edges after a move (no hit: 41); area is combinational.
// Backpressure: none; moves arriving mid-scan are picked up afterwards because the latch still differs.
module blocks
    import breakout_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        endgame,
    input  logic [9:0]  next_x,
    input  logic [9:0]  next_y,
    blocks_if.slave     ball,
    output logic        area,
    output logic        scan_busy,
    output logic [15:0] score,
    output logic [5:0]  bricks_left,
    output logic        all_clear
);

    state_t                state_q, state_d;
    logic [5:0]            idx_q, idx_d;
    logic [9:0]            px_q, px_d;
    logic [9:0]            py_q, py_d;
    logic [N_BRICKS-1:0]   alive_q, alive_d;
    logic [15:0]           score_q, score_d;
    logic [5:0]            left_q, left_d;
    logic                  hit_q, hit_d;
    logic [3:0]            side_q, side_d;

    logic                  overlap;
    logic [3:0]            side;
    logic [16:0]           score_sum;

    brick_overlap u_overlap (
        .x_i       (px_q),
        .y_i       (py_q),
        .idx_i     (idx_q),
        .overlap_o (overlap),
        .side_o    (side)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            px_q    <= HOME_X;
            py_q    <= HOME_Y;
            alive_q <= '1;
            score_q <= '0;
            left_q  <= 6'(N_BRICKS);
            hit_q   <= 1'b0;
            side_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            px_q    <= px_d;
            py_q    <= py_d;
            alive_q <= alive_d;
            score_q <= score_d;
            left_q  <= left_d;
            hit_q   <= hit_d;
            side_q  <= side_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        px_d      = px_q;
        py_d      = py_q;
        alive_d   = alive_q;
        score_d   = score_q;
        left_d    = left_q;
        hit_d     = hit_q;
        side_d    = side_q;
        score_sum = {1'b0, score_q} + {14'd0, brick_points(idx_q)};

        if (!start) begin
            // Dropping start restores the whole wall from any state, abandoning a scan.
            state_d = ST_CLEAR;
            idx_d   = '0;
            px_d    = HOME_X;
            py_d    = HOME_Y;
            alive_d = '1;
            score_d = '0;
            left_d  = 6'(N_BRICKS);
            hit_d   = 1'b0;
            side_d  = '0;
        end else begin
            unique case (state_q)
                ST_CLEAR: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (!endgame && ((ball.x_ball != px_q) || (ball.y_ball != py_q))) begin
                        px_d    = ball.x_ball;
                        py_d    = ball.y_ball;
                        hit_d   = 1'b0;
                        side_d  = '0;
                        idx_d   = '0;
                        state_d = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (alive_q[idx_q] && overlap) begin
                        // Flags, wall and score all update on the edge that enters COMMIT,
                        // so a hit on brick k is visible k+2 edges after the move.
                        hit_d          = 1'b1;
                        side_d         = side;
                        alive_d[idx_q] = 1'b0;
                        score_d        = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                        left_d         = left_q - 6'd1;
                        state_d        = ST_COMMIT;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_COMMIT;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
                ST_COMMIT: state_d = ST_IDLE;
                default:   state_d = ST_CLEAR;
            endcase
        end
    end

    // Per-pixel wall lookup for the VGA mixer.
    logic [9:0] ry;
    logic [3:0] pcol;
    logic [1:0] prow;
    logic [5:0] pidx;
    logic       in_band;
    logic       on_gap;

    always_comb begin
        ry      = next_y - 10'(TOP);
        pcol    = next_x[9:6];
        prow    = ry[5:4];
        pidx    = 6'(prow) * 6'(COLS) + 6'(pcol);
        in_band = (next_y >= 10'(TOP)) && (next_y < 10'(TOP + ROWS * BRICK_H));
        on_gap  = (next_x[5:0] == 6'd0) || (next_x[5:0] == 6'h3F) ||
                  (ry[3:0] == 4'd0) || (ry[3:0] == 4'hF);
        area    = in_band && !on_gap && (pcol < 4'(COLS)) && alive_q[pidx];
    end

    assign ball.hit_block   = hit_q;
    assign ball.hit_block_u = side_q[3];
    assign ball.hit_block_d = side_q[2];
    assign ball.hit_block_l = side_q[1];
    assign ball.hit_block_r = side_q[0];

    assign scan_busy   = (state_q == ST_SCAN);
    assign score       = score_q;
    assign bricks_left = left_q;
    assign all_clear   = (left_q == 6'd0);

endmodule

// File: tb/tb_blocks.sv
// Purpose: directed self-checking bench for the brick field (hits, sides, timing, abort, clear-all, endgame).
// Latency: checks sampled 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_blocks;

    logic        clock;
    logic        reset;
    logic        start;
    logic        endgame;
    logic [9:0]  next_x;
    logic [9:0]  next_y;
    logic        area;
    logic        scan_busy;
    logic [15:0] score;
    logic [5:0]  bricks_left;
    logic        all_clear;

    int errors = 0;
    int checks = 0;

    blocks_if bif ();

    blocks dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .endgame     (endgame),
        .next_x      (next_x),
        .next_y      (next_y),
        .ball        (bif),
        .area        (area),
        .scan_busy   (scan_busy),
        .score       (score),
        .bricks_left (bricks_left),
        .all_clear   (all_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic move(input int x, input int y);
        bif.x_ball = 10'(x);
        bif.y_ball = 10'(y);
    endtask

    task automatic pixel(input int x, input int y);
        next_x = 10'(x);
        next_y = 10'(y);
        #1;
    endtask

    function automatic logic [3:0] flags();
        return {bif.hit_block_u, bif.hit_block_d, bif.hit_block_l, bif.hit_block_r};
    endfunction

    initial begin
        int busy_cnt;
        int fall_at;
        int t;
        int bx;
        int by;

        reset   = 1'b0;
        start   = 1'b0;
        endgame = 1'b0;
        next_x  = 10'd100;
        next_y  = 10'd70;
        move(320, 240);
        step(3);
        reset = 1'b1;
        step(2);

        check("rst_left",  bricks_left, 40);
        check("rst_score", score, 0);
        check("rst_hit",   bif.hit_block, 0);
        check("rst_sides", flags(), 4'b0000);
        check("rst_busy",  scan_busy, 0);
        check("rst_clear", all_clear, 0);
        check("rst_area",  area, 1);

        start = 1'b1;
        step(1);

        // Just below brick 0: bottom face, first brick in order.
        move(32, 86);
        step(1);
        check("b0_busy",  scan_busy, 1);
        check("b0_early", bif.hit_block, 0);
        step(1);
        check("b0_hit",   bif.hit_block, 1);
        check("b0_side",  flags(), 4'b0100);
        check("b0_score", score, 4);
        check("b0_left",  bricks_left, 39);
        pixel(32, 70);
        check("b0_area",  area, 0);
        step(3);
        check("b0_hold",  bif.hit_block, 1);

        // Empty region: full 40-brick scan.
        move(320, 240);
        busy_cnt = 0;
        fall_at  = 0;
        for (int i = 1; i <= 60 && fall_at == 0; i++) begin
            step(1);
            if (i == 1) check("nh_flag_clear", bif.hit_block, 0);
            if (scan_busy) busy_cnt++;
            else fall_at = i;
        end
        check("nh_busy_cycles", busy_cnt, 40);
        check("nh_commit_edge", fall_at, 41);
        check("nh_hit",   bif.hit_block, 0);
        check("nh_sides", flags(), 4'b0000);
        check("nh_score", score, 4);
        step(1);

        // Box straddles bricks 11 and 12; only 11 is taken, entered from its right face.
        move(128, 88);
        step(12);
        check("st_early", bif.hit_block, 0);
        step(1);
        check("st_hit",   bif.hit_block, 1);
        check("st_side",  flags(), 4'b0001);
        check("st_score", score, 7);
        check("st_left",  bricks_left, 38);
        pixel(100, 88);
        check("st_area11", area, 0);
        pixel(160, 88);
        check("st_area12", area, 1);
        pixel(64, 70);
        check("gap_area", area, 0);
        pixel(100, 128);
        check("below_area", area, 0);
        step(1);

        // From above brick 1.
        move(96, 58);
        step(3);
        check("up_side",  flags(), 4'b1000);
        check("up_score", score, 11);
        check("up_left",  bricks_left, 37);
        step(1);

        // Start dropped mid-scan.
        move(320, 240);
        step(5);
        check("ab_busy_pre", scan_busy, 1);
        start = 1'b0;
        step(1);
        check("ab_busy",  scan_busy, 0);
        check("ab_score", score, 0);
        check("ab_left",  bricks_left, 40);
        check("ab_hit",   bif.hit_block, 0);
        pixel(32, 70);
        check("ab_area",  area, 1);
        start = 1'b1;
        step(3);
        check("ab_no_rescan", scan_busy, 0);

        // Async reset mid-scan.
        move(32, 86);
        step(2);
        check("ar_score_pre", score, 4);
        move(100, 200);
        step(5);
        check("ar_busy_pre", scan_busy, 1);
        reset = 1'b0;
        #1;
        check("ar_busy",  scan_busy, 0);
        check("ar_score", score, 0);
        check("ar_left",  bricks_left, 40);
        check("ar_hit",   bif.hit_block, 0);
        pixel(32, 70);
        check("ar_area",  area, 1);
        #2;
        reset = 1'b1;
        step(50);
        check("ar_rescan_done", scan_busy, 0);

        // Knock out every brick; brick 0 entered from the left with x-R negative.
        for (int i = 0; i < 40; i++) begin
            if (i == 0) begin
                bx = 0;
                by = 72;
            end else begin
                bx = (i % 10) * 64 + 32;
                by = 64 + (i / 10) * 16 + 8;
            end
            move(bx, by);
            t = 0;
            do begin
                step(1);
                t++;
            end while (!scan_busy && t < 5);
            while (scan_busy && t < 60) begin
                step(1);
                t++;
            end
            check("clr_hit", bif.hit_block, 1);
            if (i == 0) check("clr_left_side", flags(), 4'b0010);
        end
        check("clr_all_clear", all_clear, 1);
        check("clr_score",     score, 100);
        check("clr_left",      bricks_left, 0);
        pixel(100, 70);
        check("clr_area",      area, 0);

        // Endgame freezes scanning; flags hold.
        endgame = 1'b1;
        move(320, 240);
        step(1);
        check("eg_busy",  scan_busy, 0);
        step(5);
        check("eg_busy2", scan_busy, 0);
        check("eg_hold",  bif.hit_block, 1);
        check("eg_score", score, 100);
        endgame = 1'b0;
        step(2);
        check("eg_release", scan_busy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
